// File: rtl/shf_barrel_pipe.sv
// Pipelined barrel shifter: logical left/right, arithmetic right and rotate left, with a tag sideband.
// Define SHF_BARREL_PIPE_STICKY_EN to build the sticky (OR of discarded bits) path; otherwise o_sticky is 0.
module shf_barrel_pipe #(
    parameter int SIZE_DATA      = 32,
    parameter int SIZE_SHIFT     = 5,
    parameter int STAGES_PER_REG = 2,
    parameter int SIZE_TAG       = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_mode,
    input  logic [SIZE_SHIFT-1:0] i_shift_number,
    input  logic [SIZE_DATA-1:0]  i_data,
    input  logic [SIZE_TAG-1:0]   i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic                  o_sticky,
    output logic [SIZE_TAG-1:0]   o_tag
);

    localparam int NUM_REGS = (SIZE_SHIFT + STAGES_PER_REG - 1) / STAGES_PER_REG;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high.
    // The whole pipe moves as one unit whenever the output register is empty or being consumed.
    logic adv;
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    genvar g, k;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : grp
            localparam int FIRST = g * STAGES_PER_REG;
            localparam int AW    = SIZE_SHIFT - FIRST;
            localparam int NST   = (AW < STAGES_PER_REG) ? AW : STAGES_PER_REG;

            logic                 valid_in;
            logic [1:0]           mode_in;
            logic [AW-1:0]        amt_in;
            logic [SIZE_TAG-1:0]  tag_in;
            logic [SIZE_DATA-1:0] data_in;
            logic                 valid_q;
            logic [SIZE_DATA-1:0] data_d;
            logic [SIZE_DATA-1:0] data_q;
            logic [SIZE_TAG-1:0]  tag_q;
`ifdef SHF_BARREL_PIPE_STICKY_EN
            logic                 sticky_in;
            logic                 sticky_d;
            logic                 sticky_q;
`endif

            if (g == 0) begin : src
                assign valid_in  = i_valid;
                assign mode_in   = i_mode;
                assign amt_in    = i_shift_number;
                assign tag_in    = i_tag;
                assign data_in   = i_data;
`ifdef SHF_BARREL_PIPE_STICKY_EN
                assign sticky_in = 1'b0;
`endif
            end else begin : src
                assign valid_in  = grp[g-1].valid_q;
                assign mode_in   = grp[g-1].fwd.mode_q;
                assign amt_in    = grp[g-1].fwd.amt_q;
                assign tag_in    = grp[g-1].tag_q;
                assign data_in   = grp[g-1].data_q;
`ifdef SHF_BARREL_PIPE_STICKY_EN
                assign sticky_in = grp[g-1].sticky_q;
`endif
            end

            for (k = 0; k < NST; k++) begin : stg
                localparam int SH = 1 << (FIRST + k);
                logic [SIZE_DATA-1:0] din;
                logic [SIZE_DATA-1:0] shifted;
                logic [SIZE_DATA-1:0] dout;

                if (k == 0) begin : from_grp
                    assign din = data_in;
                end else begin : from_stg
                    assign din = stg[k-1].dout;
                end

                always_comb begin
                    shifted = din;
                    unique case (mode_in)
                        2'b00:   shifted = din << SH;
                        2'b01:   shifted = din >> SH;
                        2'b10:   shifted = $unsigned($signed(din) >>> SH);
                        default: shifted = (din << SH) | (din >> (SIZE_DATA - SH));
                    endcase
                end
                assign dout = amt_in[k] ? shifted : din;

`ifdef SHF_BARREL_PIPE_STICKY_EN
                logic sin;
                logic lost;
                logic sout;
                if (k == 0) begin : s_from_grp
                    assign sin = sticky_in;
                end else begin : s_from_stg
                    assign sin = stg[k-1].sout;
                end

                // Bits leaving above the MSB (left) or below the LSB (right); rotation loses nothing.
                always_comb begin
                    lost = 1'b0;
                    unique case (mode_in)
                        2'b00:        lost = |(din >> (SIZE_DATA - SH));
                        2'b01, 2'b10: lost = |(din << (SIZE_DATA - SH));
                        default:      lost = 1'b0;
                    endcase
                end
                assign sout = sin | (amt_in[k] & lost);
`endif
            end

            assign data_d = stg[NST-1].dout;
`ifdef SHF_BARREL_PIPE_STICKY_EN
            assign sticky_d = stg[NST-1].sout;
`endif

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    tag_q   <= '0;
                end else if (adv) begin
                    valid_q <= valid_in;
                    data_q  <= data_d;
                    tag_q   <= tag_in;
                end
            end

`ifdef SHF_BARREL_PIPE_STICKY_EN
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sticky_q <= 1'b0;
                end else if (adv) begin
                    sticky_q <= sticky_d;
                end
            end
`endif

            // Only intermediate registers carry the mode and the shift bits not yet consumed.
            if (g < NUM_REGS - 1) begin : fwd
                logic [1:0]        mode_q;
                logic [AW-NST-1:0] amt_q;
                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        mode_q <= '0;
                        amt_q  <= '0;
                    end else if (adv) begin
                        mode_q <= mode_in;
                        amt_q  <= amt_in[AW-1:NST];
                    end
                end
            end
        end
    endgenerate

    assign o_valid = grp[NUM_REGS-1].valid_q;
    assign o_data  = grp[NUM_REGS-1].data_q;
    assign o_tag   = grp[NUM_REGS-1].tag_q;
`ifdef SHF_BARREL_PIPE_STICKY_EN
    assign o_sticky = grp[NUM_REGS-1].sticky_q;
`else
    assign o_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shf_barrel_pipe.sv
// Testbench for shf_barrel_pipe: directed vectors, stall/stream and random traffic against a wide-arithmetic model.
// Sticky expectations follow SHF_BARREL_PIPE_STICKY_EN (expected 0 when undefined).
module tb_shf_barrel_pipe;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int TW = 4;
    localparam int EW = DW + TW + 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [1:0]    i_mode;
    logic [SW-1:0] i_shift_number;
    logic [DW-1:0] i_data;
    logic [TW-1:0] i_tag;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_sticky;
    logic [TW-1:0] o_tag;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;

    logic [EW-1:0] exp_q[$];
    logic          held_v = 1'b0;
    logic [EW-1:0] held;

    shf_barrel_pipe #(
        .SIZE_DATA(DW), .SIZE_SHIFT(SW), .STAGES_PER_REG(2), .SIZE_TAG(TW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_shift_number(i_shift_number), .i_data(i_data), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sticky(o_sticky), .o_tag(o_tag)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a 64-bit window; result and discarded bits fall out directly.
    function automatic logic [EW-1:0] model(input logic [1:0] m, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s, input logic [TW-1:0] t);
        logic [63:0]   wide;
        logic [DW-1:0] r;
        logic          st;
        int            n;
        n = int'(s);
        case (m)
            2'b00: begin wide = {32'b0, d} << n; r = wide[31:0];  st = |wide[63:32]; end
            2'b01: begin wide = {d, 32'b0} >> n; r = wide[63:32]; st = |wide[31:0];  end
            2'b10: begin wide = $signed({d, 32'b0}) >>> n; r = wide[63:32]; st = |wide[31:0]; end
            default: begin wide = {d, d} << n; r = wide[63:32]; st = 1'b0; end
        endcase
`ifndef SHF_BARREL_PIPE_STICKY_EN
        st = 1'b0;
`endif
        return {st, t, r};
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge i_clk) begin
        logic [EW-1:0] e;
        if (i_rst) begin
            held_v = 1'b0;
        end else begin
            check("ready", o_ready, (!o_valid || i_ready));
            if (held_v && o_valid)
                check("hold", {o_sticky, o_tag, o_data}, held);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious", o_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", o_data, e[DW-1:0]);
                    check("tag", o_tag, e[DW+TW-1:DW]);
                    check("sticky", o_sticky, e[EW-1]);
                    n_out++;
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_mode, i_data, i_shift_number, i_tag));
                n_in++;
            end
            held_v = o_valid && !i_ready;
            held   = {o_sticky, o_tag, o_data};
        end
    end

    // driver tasks
    task automatic directed(input string nm, input logic [1:0] m, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [TW-1:0] t,
                            input logic [DW-1:0] ed, input logic es);
        int n;
        logic exp_st;
        exp_st = es;
`ifndef SHF_BARREL_PIPE_STICKY_EN
        exp_st = 1'b0;
`endif
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_mode = m; i_data = d; i_shift_number = s; i_tag = t;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        check({nm, "_lat"}, n, 3);
        check({nm, "_data"}, o_data, ed);
        check({nm, "_sticky"}, o_sticky, exp_st);
        check({nm, "_tag"}, o_tag, t);
        @(posedge i_clk); #1;
    endtask

    task automatic drain();
        int n;
        i_valid = 1'b0;
        i_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        check("count", n_out, n_in);
    endtask

    task automatic stream(input int nbeats, input int stall_lo, input int stall_hi,
                          input int valid_pct, input int ready_pct);
        int  sent;
        int  c;
        bit  pend;
        bit  stall;
        sent = 0; c = 0; pend = 1'b0;
        while (sent < nbeats && c < 5000) begin
            if (!pend && $urandom_range(99) < valid_pct) begin
                pend = 1'b1;
                i_mode = 2'($urandom);
                i_shift_number = ($urandom_range(7) == 0) ? '0 : SW'($urandom);
                i_data = $urandom;
                i_tag = TW'($urandom);
            end
            i_valid = pend;
            stall = (c >= stall_lo) && (c <= stall_hi);
            i_ready = stall ? 1'b0 : ($urandom_range(99) < ready_pct);
            @(negedge i_clk);
            if (stall && o_valid) check("stall_rdy", o_ready, 1'b0);
            if (pend && o_ready) begin
                pend = 1'b0;
                sent++;
            end
            @(posedge i_clk); #1;
            c++;
        end
        check("stream_sent", sent, nbeats);
        drain();
    endtask

    initial begin
        logic [DW-1:0] d;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_mode = '0; i_shift_number = '0; i_data = '0; i_tag = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_sticky", o_sticky, 1'b0);
        check("rst_tag", o_tag, '0);
        check("rst_ready", o_ready, 1'b1);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("post_rst_valid", o_valid, 1'b0);
        check("post_rst_ready", o_ready, 1'b1);

        directed("lsl4", 2'b00, 32'h8000_0001, 5'd4, 4'h5, 32'h0000_0010, 1'b1);
        directed("asr4", 2'b10, 32'h8000_00F0, 5'd4, 4'h1, 32'hF800_000F, 1'b0);
        directed("lsr4", 2'b01, 32'h8000_00F0, 5'd4, 4'h2, 32'h0800_000F, 1'b0);
        directed("lsr5", 2'b01, 32'h8000_00F0, 5'd5, 4'h3, 32'h0400_0007, 1'b1);
        directed("rol8", 2'b11, 32'h1234_5678, 5'd8, 4'h9, 32'h3456_7812, 1'b0);
        directed("asr31", 2'b10, 32'h8000_0000, 5'd31, 4'hA, 32'hFFFF_FFFF, 1'b0);
        directed("lsl31", 2'b00, 32'h0000_0003, 5'd31, 4'hB, 32'h8000_0000, 1'b1);
        for (int m = 0; m < 4; m++) begin
            d = $urandom;
            directed("shift0", 2'(m), d, 5'd0, 4'(m), d, 1'b0);
        end

        // back-to-back beats with a three-cycle downstream stall
        stream(10, 5, 7, 100, 100);
        // random traffic with random valid/ready gaps
        stream(300, -1, -1, 70, 70);
        stream(100, -1, -1, 100, 100);

        // reset with three beats in flight
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_mode = 2'($urandom); i_shift_number = SW'($urandom);
            i_data = $urandom; i_tag = TW'($urandom);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        exp_q.delete();
        @(posedge i_clk); #1;
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_data", o_data, '0);
        check("mid_rst_tag", o_tag, '0);
        check("mid_rst_sticky", o_sticky, 1'b0);
        check("mid_rst_ready", o_ready, 1'b1);
        i_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            check("no_stale", o_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shf_barrel_pipe.md
SHF_BARREL_PIPE -- requirements
Module: shf_barrel_pipe

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 32, data width in bits.
REQ-002 SHALL have parameter SIZE_SHIFT, default 5, shift-amount width; legal only if 2**(SIZE_SHIFT-1) < SIZE_DATA.
REQ-003 SHALL have parameter STAGES_PER_REG, default 2, shift stages (1..SIZE_SHIFT) between pipeline registers.
REQ-004 SHALL have parameter SIZE_TAG, default 4, sideband tag width.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  input beat valid.
REQ-008 o_ready  output  1  block accepts a beat this cycle.
REQ-009 i_mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
REQ-010 i_shift_number  input  SIZE_SHIFT  shift amount.
REQ-011 i_data  input  SIZE_DATA  operand.
REQ-012 i_tag  input  SIZE_TAG  sideband, passed through unchanged.
REQ-013 o_valid  output  1  result valid.
REQ-014 i_ready  input  1  downstream accepts result.
REQ-015 o_data  output  SIZE_DATA  shifted result.
REQ-016 o_sticky  output  1  OR of bits discarded by the shift.
REQ-017 o_tag  output  SIZE_TAG  tag aligned with o_data.

Function
REQ-018 Shift SHALL decompose into SIZE_SHIFT binary stages; stage i shifts by 2**i when i_shift_number[i]=1.
REQ-019 A pipeline register SHALL follow every STAGES_PER_REG stages and the final stage; latency L = ceil(SIZE_SHIFT/STAGES_PER_REG) cycles from accepted input to o_valid.
REQ-020 Mode, remaining shift bits, tag, sticky and valid SHALL travel with data through each register.
REQ-021 Logical left SHALL zero-fill LSBs; logical right SHALL zero-fill MSBs; arithmetic right SHALL fill with the input MSB; rotate left SHALL wrap MSBs into LSBs.
REQ-022 Sticky SHALL accumulate per stage: bits exiting above MSB (left) or below LSB (right modes); rotate SHALL give sticky 0.
REQ-023 Shift amount 0 SHALL return i_data unchanged with o_sticky=0.
REQ-024 Pipeline SHALL advance when adv = ~o_valid | i_ready; o_ready SHALL equal adv combinationally.
REQ-025 When adv=0 every register SHALL hold; o_data/o_tag/o_sticky SHALL stay stable while o_valid=1 and i_ready=0.
REQ-026 Input accepted iff i_valid & o_ready; when adv=1 and i_valid=0 a bubble (valid=0) SHALL enter.
REQ-027 Full throughput: one result per cycle when i_ready held 1; results in input order, no loss or duplication.
REQ-028 Simultaneous output consume and input accept in the same cycle SHALL both take effect.

Reset
REQ-029 i_rst=1 at a rising edge SHALL clear every stage valid, data, tag and sticky register to 0.
REQ-030 During and the cycle after reset o_valid=0, o_data=0, o_sticky=0, o_tag=0; o_ready=1.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; none emerge afterward.

Configuration
REQ-032 Macro SHF_BARREL_PIPE_STICKY_EN defined: sticky logic and registers built per REQ-022.
REQ-033 Macro undefined: no sticky logic or registers; o_sticky SHALL be constant 0; all other behaviour identical.

Verification (SIZE_DATA=32, SIZE_SHIFT=5, STAGES_PER_REG=2, L=3, macro defined)
REQ-034 Mode 00, data 0x8000_0001, shift 4, tag 0x5 -> 3 cycles later o_data 0x0000_0010, o_sticky 1, o_tag 0x5.
REQ-035 Mode 10, data 0x8000_00F0, shift 4 -> 0xF800_000F, sticky 0; mode 01 same input -> 0x0800_000F, sticky 0; shift 5 mode 01 -> 0x0400_0007, sticky 1.
REQ-036 Mode 11, data 0x1234_5678, shift 8 -> 0x3456_7812, sticky 0; shift 0 any mode -> data unchanged, sticky 0.
REQ-037 Back-to-back 10 beats, i_ready=0 for cycles 5-7 -> o_ready=0 while stalled, outputs held stable, all 10 results in order, none lost.
REQ-038 Assert i_rst with 3 beats in flight -> next cycle o_valid=0, o_data=0, o_ready=1; no stale beat appears later.
REQ-039 Macro undefined, repeat REQ-034 -> o_data 0x0000_0010, o_sticky 0.
